// File: rtl/down_fifo_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : down_fifo_burst_ctrl_if
// Brief    : Burst command channel and word stream towards the frame-buffer
//            write master.
// Revision : 1.0
// ============================================================================
interface down_fifo_burst_ctrl_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 28
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (
        output cmd_valid, cmd_addr, m_data, m_valid, m_last,
        input  cmd_ready, m_ready
    );

    modport slave (
        input  cmd_valid, cmd_addr, m_data, m_valid, m_last,
        output cmd_ready, m_ready
    );
endinterface
`default_nettype wire

// File: rtl/down_fifo_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : down_fifo_burst_ctrl
// Brief    : Read-side burst scheduler for the downscaled-pixel async FIFO:
//            issues burst commands and streams BURST_LEN words per burst.
// Revision : 1.0
// ============================================================================
module down_fifo_burst_ctrl #(
    parameter int DATA_WIDTH  = 24,
    parameter int BURST_LEN   = 16,
    parameter int LINE_WORDS  = 640,
    parameter int FRAME_LINES = 480,
    parameter int ADDR_WIDTH  = 28
) (
    input  wire                    rd_clk,
    input  wire                    rd_rst,
    input  wire                    enable,
    input  wire                    frame_start,
    input  wire                    fifo_empty,
    input  wire                    fifo_almost_empty,
    output logic                   fifo_rd_en,
    input  wire [DATA_WIDTH-1:0]   fifo_rd_data,
    output logic                   frame_done,
    output logic [15:0]            line_cnt,
    output logic                   busy,
    down_fifo_burst_ctrl_if.master bus
);

    localparam int                  c_CW        = $clog2(BURST_LEN) + 1;
    localparam int                  c_BPL       = LINE_WORDS / BURST_LEN;
    localparam logic [c_CW-1:0]     c_BL        = c_CW'(BURST_LEN);
    localparam logic [c_CW-1:0]     c_BL_LAST   = c_CW'(BURST_LEN - 1);
    localparam logic [15:0]         c_BPL_LAST  = 16'(c_BPL - 1);
    localparam logic [15:0]         c_LINE_LAST = 16'(FRAME_LINES - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_INC = ADDR_WIDTH'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DATA = 3'd1,
        S_CMD       = 3'd2,
        S_DATA      = 3'd3,
        S_NEXT      = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_cmd_valid;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_fs_pending;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [15:0]           r_line_cnt;
    logic [15:0]           r_burst_in_line;
    logic [c_CW-1:0]       r_issued;
    logic [c_CW-1:0]       r_popped;

    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf [0:3];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_buf_cnt;

    logic                  w_m_valid;
    logic                  w_pop;
    logic                  w_last_pop;
    logic                  w_last_burst;

    assign w_m_valid    = (r_buf_cnt != 3'd0);
    assign w_pop        = w_m_valid & bus.m_ready;
    assign w_last_pop   = w_pop & (r_popped == c_BL_LAST);
    assign w_last_burst = (r_line_cnt == c_LINE_LAST) & (r_burst_in_line == c_BPL_LAST);

    // The read strobe looks at the live empty flag so a read never passes it;
    // the occupancy term counts the word still in flight from the FIFO.
    assign fifo_rd_en = (r_state == S_DATA) & ~fifo_empty & (r_issued < c_BL) &
                        (({1'b0, r_buf_cnt} + {3'b000, r_inflight}) < 4'd4);

    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_addr  = r_cmd_addr;
    assign bus.m_data    = r_buf[r_rd_ptr];
    assign bus.m_valid   = w_m_valid;
    assign bus.m_last    = w_m_valid & (r_popped == c_BL_LAST);
    assign frame_done    = r_frame_done;
    assign line_cnt      = r_line_cnt;
    assign busy          = r_busy;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_inflight <= 1'b0;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_buf_cnt  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_inflight <= fifo_rd_en;
            if (r_inflight) begin
                r_buf[r_wr_ptr] <= fifo_rd_data;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_buf_cnt <= r_buf_cnt + {2'b00, r_inflight} - {2'b00, w_pop};
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_state         <= S_IDLE;
            r_cmd_valid     <= 1'b0;
            r_busy          <= 1'b0;
            r_frame_done    <= 1'b0;
            r_fs_pending    <= 1'b0;
            r_cmd_addr      <= '0;
            r_line_cnt      <= 16'd0;
            r_burst_in_line <= 16'd0;
            r_issued        <= '0;
            r_popped        <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (fifo_rd_en) begin
                r_issued <= r_issued + c_CW'(1);
            end
            if (w_pop) begin
                r_popped <= r_popped + c_CW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_cmd_addr      <= '0;
                        r_line_cnt      <= 16'd0;
                        r_burst_in_line <= 16'd0;
                    end
                    if (enable) begin
                        r_state <= S_WAIT_DATA;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT_DATA: begin
                    if (frame_start) begin
                        r_cmd_addr      <= '0;
                        r_line_cnt      <= 16'd0;
                        r_burst_in_line <= 16'd0;
                    end
                    if (!fifo_almost_empty) begin
                        r_state     <= S_CMD;
                        r_cmd_valid <= 1'b1;
                    end
                end
                S_CMD: begin
                    if (frame_start) begin
                        r_fs_pending <= 1'b1;
                    end
                    if (bus.cmd_ready) begin
                        r_state     <= S_DATA;
                        r_cmd_valid <= 1'b0;
                        r_issued    <= '0;
                        r_popped    <= '0;
                    end
                end
                S_DATA: begin
                    if (frame_start) begin
                        r_fs_pending <= 1'b1;
                    end
                    if (w_last_pop) begin
                        r_state      <= S_NEXT;
                        r_frame_done <= w_last_burst & ~r_fs_pending & ~frame_start;
                    end
                end
                S_NEXT: begin
                    // A rewind request outranks the normal address advance.
                    if (frame_start | r_fs_pending | w_last_burst) begin
                        r_cmd_addr      <= '0;
                        r_line_cnt      <= 16'd0;
                        r_burst_in_line <= 16'd0;
                    end else begin
                        r_cmd_addr <= r_cmd_addr + c_ADDR_INC;
                        if (r_burst_in_line == c_BPL_LAST) begin
                            r_burst_in_line <= 16'd0;
                            r_line_cnt      <= r_line_cnt + 16'd1;
                        end else begin
                            r_burst_in_line <= r_burst_in_line + 16'd1;
                        end
                    end
                    r_fs_pending <= 1'b0;
                    r_busy       <= enable;
                    r_state      <= enable ? S_WAIT_DATA : S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_down_fifo_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_down_fifo_burst_ctrl
// Brief    : Scoreboard bench for down_fifo_burst_ctrl with a small FIFO model.
// Revision : 1.0
// ============================================================================
module tb_down_fifo_burst_ctrl;

    localparam int DW = 24;
    localparam int AW = 28;

    logic          clk;
    logic          rd_rst;
    logic          enable;
    logic          frame_start;
    logic          fifo_empty;
    logic          fifo_almost_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          frame_done;
    logic [15:0]   line_cnt;
    logic          busy;

    down_fifo_burst_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if();

    down_fifo_burst_ctrl #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (4),
        .LINE_WORDS (8),
        .FRAME_LINES(2),
        .ADDR_WIDTH (AW)
    ) u_dut (
        .rd_clk           (clk),
        .rd_rst           (rd_rst),
        .enable           (enable),
        .frame_start      (frame_start),
        .fifo_empty       (fifo_empty),
        .fifo_almost_empty(fifo_almost_empty),
        .fifo_rd_en       (fifo_rd_en),
        .fifo_rd_data     (fifo_rd_data),
        .frame_done       (frame_done),
        .line_cnt         (line_cnt),
        .busy             (busy),
        .bus              (bus_if.master)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [DW-1:0]   fifo_q[$];
    int              fifo_cnt    = 0;
    logic            force_empty = 1'b0;
    logic            override_ae = 1'b0;
    logic [DW:0]     exp_q[$];
    logic [43:0]     exp_cmd_q[$];
    int              hs_cyc_q[$];
    int              word_idx = 0;
    int              hs_cnt   = 0;
    int              fd_cnt   = 0;
    int              reads    = 0;
    int              pops     = 0;
    logic            prev_vhold = 1'b0;
    logic [DW-1:0]   prev_data  = '0;
    logic            prev_chold = 1'b0;
    logic [AW-1:0]   prev_addr  = '0;

    assign fifo_empty        = (fifo_cnt == 0) || force_empty;
    assign fifo_almost_empty = override_ae ? 1'b0 : (fifo_cnt < 4);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            n_checks++;
            if (fifo_q.size() == 0) begin
                n_errors++;
                $display("FAIL fifo_underflow: read strobe with 0 words stored, required at least 1");
            end else begin
                fifo_rd_data <= fifo_q.pop_front();
            end
            fifo_cnt <= fifo_q.size();
        end
    end

    // Sink monitor: samples mid-cycle, so it sees what the next edge acts on.
    always @(negedge clk) begin
        logic [DW:0] e;
        logic [43:0] c;
        if (rd_rst) begin
            prev_vhold = 1'b0;
            prev_chold = 1'b0;
            reads      = 0;
            pops       = 0;
        end else begin
            if (prev_vhold) begin
                n_checks++;
                if (bus_if.m_valid !== 1'b1 || bus_if.m_data !== prev_data) begin
                    n_errors++;
                    $display("FAIL stream_hold: valid=%b data=%h, required valid=1 data=%h",
                             bus_if.m_valid, bus_if.m_data, prev_data);
                end
            end
            if (bus_if.m_valid === 1'b1 && bus_if.m_ready === 1'b1) begin
                n_checks++;
                pops++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL stream_extra: got word %h with no word expected", bus_if.m_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus_if.m_last, bus_if.m_data} !== e) begin
                        n_errors++;
                        $display("FAIL stream_word: last=%b data=%h, required last=%b data=%h",
                                 bus_if.m_last, bus_if.m_data, e[DW], e[DW-1:0]);
                    end
                end
            end
            if (fifo_rd_en === 1'b1) begin
                reads++;
                n_checks++;
                if (reads - pops > 4) begin
                    n_errors++;
                    $display("FAIL outstanding: %0d words outstanding, required at most 4", reads - pops);
                end
            end
            prev_vhold = (bus_if.m_valid === 1'b1) && (bus_if.m_ready !== 1'b1);
            prev_data  = bus_if.m_data;

            if (prev_chold) begin
                n_checks++;
                if (bus_if.cmd_valid !== 1'b1 || bus_if.cmd_addr !== prev_addr) begin
                    n_errors++;
                    $display("FAIL cmd_hold: valid=%b addr=%0d, required valid=1 addr=%0d",
                             bus_if.cmd_valid, bus_if.cmd_addr, prev_addr);
                end
            end
            if (bus_if.cmd_valid === 1'b1 && bus_if.cmd_ready === 1'b1) begin
                n_checks++;
                hs_cnt++;
                hs_cyc_q.push_back(cyc);
                if (exp_cmd_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL cmd_extra: command addr=%0d with none expected", bus_if.cmd_addr);
                end else begin
                    c = exp_cmd_q.pop_front();
                    if ({line_cnt, bus_if.cmd_addr} !== c) begin
                        n_errors++;
                        $display("FAIL cmd_addr_line: addr=%0d line=%0d, required addr=%0d line=%0d",
                                 bus_if.cmd_addr, line_cnt, c[AW-1:0], c[43:28]);
                    end
                end
            end
            prev_chold = (bus_if.cmd_valid === 1'b1) && (bus_if.cmd_ready !== 1'b1);
            prev_addr  = bus_if.cmd_addr;

            if (frame_done === 1'b1) begin
                fd_cnt++;
                n_checks++;
                if (exp_q.size() != 0) begin
                    n_errors++;
                    $display("FAIL frame_done_early: %0d words still due, required 0", exp_q.size());
                end
            end
        end
    end

    task automatic push_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + DW'(i));
            exp_q.push_back({(word_idx % 4) == 3, base + DW'(i)});
            word_idx++;
        end
        fifo_cnt = fifo_q.size();
    endtask

    task automatic wait_hs(input int target, input string name);
        int budget = 100;
        while (hs_cnt < target && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (hs_cnt < target) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: %0d commands accepted, required %0d", name, hs_cnt, target);
        end
    endtask

    task automatic wait_drain(input bit toggle_ready, input string name);
        int budget = 400;
        while ((exp_q.size() != 0 || exp_cmd_q.size() != 0) && budget > 0) begin
            @(posedge clk); #1;
            if (toggle_ready) bus_if.m_ready = ~bus_if.m_ready;
            budget--;
        end
        bus_if.m_ready = 1'b1;
        if (exp_q.size() != 0 || exp_cmd_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: %0d words and %0d commands outstanding, required 0",
                     name, exp_q.size(), exp_cmd_q.size());
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rd_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 9;
        if (fifo_rd_en !== 1'b0)       begin n_errors++; $display("FAIL rst_fifo_rd_en: %b, required 0", fifo_rd_en); end
        if (bus_if.cmd_valid !== 1'b0) begin n_errors++; $display("FAIL rst_cmd_valid: %b, required 0", bus_if.cmd_valid); end
        if (bus_if.cmd_addr !== '0)    begin n_errors++; $display("FAIL rst_cmd_addr: %0d, required 0", bus_if.cmd_addr); end
        if (bus_if.m_data !== '0)      begin n_errors++; $display("FAIL rst_m_data: %h, required 0", bus_if.m_data); end
        if (bus_if.m_valid !== 1'b0)   begin n_errors++; $display("FAIL rst_m_valid: %b, required 0", bus_if.m_valid); end
        if (bus_if.m_last !== 1'b0)    begin n_errors++; $display("FAIL rst_m_last: %b, required 0", bus_if.m_last); end
        if (frame_done !== 1'b0)       begin n_errors++; $display("FAIL rst_frame_done: %b, required 0", frame_done); end
        if (line_cnt !== 16'd0)        begin n_errors++; $display("FAIL rst_line_cnt: %0d, required 0", line_cnt); end
        if (busy !== 1'b0)             begin n_errors++; $display("FAIL rst_busy: %b, required 0", busy); end
        rd_rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        int fd_base = fd_cnt;
        hs_cyc_q.delete();
        exp_cmd_q.push_back({16'd0, 28'd0});
        exp_cmd_q.push_back({16'd0, 28'd4});
        exp_cmd_q.push_back({16'd1, 28'd8});
        exp_cmd_q.push_back({16'd1, 28'd12});
        push_words(16, 24'd0);
        enable = 1'b1;
        wait_drain(1'b0, "full_frame");
        n_checks += 4;
        if (fd_cnt - fd_base != 1) begin
            n_errors++;
            $display("FAIL frame_done_count: %0d pulse cycles, required 1", fd_cnt - fd_base);
        end
        if (line_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL frame_line_wrap: line_cnt=%0d, required 0", line_cnt);
        end
        if (bus_if.cmd_addr !== '0) begin
            n_errors++;
            $display("FAIL frame_addr_wrap: cmd_addr=%0d, required 0", bus_if.cmd_addr);
        end
        if (hs_cyc_q.size() != 4 || hs_cyc_q[1] - hs_cyc_q[0] != 9) begin
            n_errors++;
            $display("FAIL burst_spacing: %0d commands, gap=%0d cycles, required 4 commands gap 9",
                     hs_cyc_q.size(), (hs_cyc_q.size() > 1) ? hs_cyc_q[1] - hs_cyc_q[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        exp_cmd_q.push_back({16'd0, 28'd0});
        exp_cmd_q.push_back({16'd0, 28'd4});
        push_words(8, 24'h100000);
        wait_drain(1'b1, "backpressure");
    endtask

    task automatic test_empty_stall();
        int base = hs_cnt;
        exp_cmd_q.push_back({16'd1, 28'd8});
        override_ae = 1'b1;
        push_words(2, 24'h200000);
        wait_hs(base + 1, "stall_cmd");
        override_ae = 1'b0;
        force_empty = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        force_empty = 1'b0;
        push_words(2, 24'h200002);
        wait_drain(1'b0, "empty_stall");
    endtask

    task automatic test_delayed_cmd();
        int fd_base = fd_cnt;
        int budget  = 50;
        bus_if.cmd_ready = 1'b0;
        exp_cmd_q.push_back({16'd1, 28'd12});
        push_words(4, 24'h300000);
        while (bus_if.cmd_valid !== 1'b1 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks += 3;
            if (bus_if.cmd_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL delay_cmd_valid: %b, required 1", bus_if.cmd_valid);
            end
            if (bus_if.cmd_addr !== 28'd12) begin
                n_errors++;
                $display("FAIL delay_cmd_addr: %0d, required 12", bus_if.cmd_addr);
            end
            if (fifo_rd_en !== 1'b0) begin
                n_errors++;
                $display("FAIL delay_rd_en: %b, required 0", fifo_rd_en);
            end
            @(posedge clk); #1;
        end
        bus_if.cmd_ready = 1'b1;
        wait_drain(1'b0, "delayed_cmd");
        n_checks++;
        if (fd_cnt - fd_base != 1) begin
            n_errors++;
            $display("FAIL delay_frame_done: %0d pulse cycles, required 1", fd_cnt - fd_base);
        end
    endtask

    task automatic test_frame_start();
        int fd_base = fd_cnt;
        int base    = hs_cnt;
        exp_cmd_q.push_back({16'd0, 28'd0});
        exp_cmd_q.push_back({16'd0, 28'd4});
        exp_cmd_q.push_back({16'd1, 28'd8});
        exp_cmd_q.push_back({16'd0, 28'd0});
        push_words(16, 24'h400000);
        wait_hs(base + 3, "fs_cmd");
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        wait_drain(1'b0, "frame_start");
        n_checks += 3;
        if (fd_cnt != fd_base) begin
            n_errors++;
            $display("FAIL fs_frame_done: %0d pulse cycles, required 0", fd_cnt - fd_base);
        end
        if (bus_if.cmd_addr !== 28'd4) begin
            n_errors++;
            $display("FAIL fs_next_addr: %0d, required 4", bus_if.cmd_addr);
        end
        if (line_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL fs_line_cnt: %0d, required 0", line_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int base = hs_cnt;
        exp_cmd_q.push_back({16'd0, 28'd4});
        push_words(4, 24'h500000);
        wait_hs(base + 1, "rst_cmd");
        repeat (2) begin
            @(posedge clk); #1;
        end
        rd_rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({fifo_rd_en, bus_if.cmd_valid, bus_if.cmd_addr, bus_if.m_data, bus_if.m_valid,
             bus_if.m_last, frame_done, line_cnt, busy} !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_outputs: rd_en=%b cv=%b addr=%0d data=%h mv=%b ml=%b fd=%b line=%0d busy=%b, required all 0",
                     fifo_rd_en, bus_if.cmd_valid, bus_if.cmd_addr, bus_if.m_data, bus_if.m_valid,
                     bus_if.m_last, frame_done, line_cnt, busy);
        end
        fifo_q.delete();
        exp_q.delete();
        exp_cmd_q.delete();
        fifo_cnt = 0;
        word_idx = 0;
        @(posedge clk); #1;
        rd_rst = 1'b0;
        exp_cmd_q.push_back({16'd0, 28'd0});
        push_words(4, 24'h600000);
        wait_drain(1'b0, "reset_mid");
        n_checks++;
        if (bus_if.cmd_addr !== 28'd4) begin
            n_errors++;
            $display("FAIL post_reset_addr: %0d, required 4", bus_if.cmd_addr);
        end
    endtask

    initial begin
        rd_rst           = 1'b1;
        enable           = 1'b0;
        frame_start      = 1'b0;
        fifo_rd_data     = '0;
        bus_if.cmd_ready = 1'b1;
        bus_if.m_ready   = 1'b1;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_empty_stall();
        test_delayed_cmd();
        test_frame_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
